// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared constants and types for the BIST pattern-generator chain that drives
// the 36 inputs of the c432 combinational benchmark.
//   LFSR_LEN     : number of cells in the chain
//   LFSR_TAP_A/B : state bits XNORed to form the feedback
//   lfsr_state_t : full chain state vector
// ---------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_LEN   = 36;
  localparam int LFSR_TAP_A = 24;
  localparam int LFSR_TAP_B = 35;

  typedef logic [LFSR_LEN-1:0] lfsr_state_t;

endpackage : lfsr_pkg

// File: rtl/lfsr_chain.sv
// ---------------------------------------------------------------------------
// lfsr_chain
// 36-cell pattern generator built from lfsr cells chained q->d. Feedback is
// XNOR of state bits LFSR_TAP_A and LFSR_TAP_B, registered in its own flop
// (reset to 0) before it enters cell 0. The XNOR form makes the all-zero
// reset state a legal, non-stuck starting point.
//
// Ports
//   clk     in   1         rising-edge clock
//   reset   in   1         asynchronous, active-high reset
//   scan_en in   1         (LFSR_SCAN_EN only) shift scan_in through the cells
//   scan_in in   1         (LFSR_SCAN_EN only) serial scan data into cell 0
//   state   out  LFSR_LEN  chain state, bit 0 is the cell fed by the feedback
//   fb      out  1         registered feedback bit
//
// Configuration macro: LFSR_SCAN_EN threads a serial scan path through all
// cells; the feedback flop is not part of the scan path.
// ---------------------------------------------------------------------------
module lfsr_chain
  import lfsr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef LFSR_SCAN_EN
  input  logic        scan_en,
  input  logic        scan_in,
`endif
  output lfsr_state_t state,
  output logic        fb
);

  wire  lfsr_state_t q_vec;
  logic [LFSR_LEN-1:0] d_vec;

  // Cell 0 takes the registered feedback; every other cell takes its predecessor.
  assign d_vec = {q_vec[LFSR_LEN-2:0], fb};
  assign state = q_vec;

`ifdef LFSR_SCAN_EN
  logic [LFSR_LEN-1:0] scan_vec;
  assign scan_vec = {q_vec[LFSR_LEN-2:0], scan_in};
`endif

  for (genvar i = 0; i < LFSR_LEN; i++) begin : g_cell
    lfsr #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
`ifdef LFSR_SCAN_EN
      .scan_en (scan_en),
      .scan_in (scan_vec[i]),
`endif
      .d       (d_vec[i]),
      .q       (q_vec[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fb <= 1'b0;
    end else begin
      fb <= ~(q_vec[LFSR_TAP_A] ^ q_vec[LFSR_TAP_B]);
    end
  end

endmodule : lfsr_chain

// File: rtl/lfsr.sv
// ---------------------------------------------------------------------------
// lfsr
// Single storage cell of the BIST pattern-generator chain: a D flip-flop with
// asynchronous active-high reset. It carries no feedback logic of its own; it
// is a pure one-cycle delay element.
//
// Parameters
//   WIDTH     : data width of d/q (the chain uses 1)
//   RESET_VAL : value forced onto q while reset is high
//
// Ports
//   clk     in   1      rising-edge clock
//   reset   in   1      asynchronous, active-high reset
//   scan_en in   1      (LFSR_SCAN_EN only) select scan_in instead of d
//   scan_in in   WIDTH  (LFSR_SCAN_EN only) scan data
//   d       in   WIDTH  next-state data
//   q       out  WIDTH  registered state
//
// Configuration macro: LFSR_SCAN_EN adds the scan_en/scan_in ports. When it
// is undefined the flop captures d only.
// ---------------------------------------------------------------------------
module lfsr
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
`ifdef LFSR_SCAN_EN
  input  logic             scan_en,
  input  logic [WIDTH-1:0] scan_in,
`endif
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // q comes straight from the flop, so q->d chaining has no combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
`ifdef LFSR_SCAN_EN
      q <= scan_en ? scan_in : d;
`else
      q <= d;
`endif
    end
  end

endmodule : lfsr

// File: tb/tb_lfsr.sv
// ---------------------------------------------------------------------------
// tb_lfsr
// Directed bench for the lfsr cell (1-bit and 4-bit instances) and the
// 36-cell lfsr_chain. Honours LFSR_SCAN_EN when defined.
// ---------------------------------------------------------------------------
module tb_lfsr;
  import lfsr_pkg::*;

  logic        clk;
  logic        reset;
  logic        d1;
  logic        q1;
  logic [3:0]  d4;
  logic [3:0]  q4;
  logic        creset;
  lfsr_state_t cstate;
  logic        cfb;
`ifdef LFSR_SCAN_EN
  logic        scan_en;
  logic        scan_in1;
  logic [3:0]  scan_in4;
  logic        cscan_en;
  logic        cscan_in;
`endif

  int checks = 0;
  int errors = 0;

  lfsr #(.WIDTH(1), .RESET_VAL(1'b0)) u_w1 (
    .clk     (clk),
    .reset   (reset),
`ifdef LFSR_SCAN_EN
    .scan_en (scan_en),
    .scan_in (scan_in1),
`endif
    .d       (d1),
    .q       (q1)
  );

  lfsr #(.WIDTH(4), .RESET_VAL(4'hA)) u_w4 (
    .clk     (clk),
    .reset   (reset),
`ifdef LFSR_SCAN_EN
    .scan_en (scan_en),
    .scan_in (scan_in4),
`endif
    .d       (d4),
    .q       (q4)
  );

  lfsr_chain u_chain (
    .clk     (clk),
    .reset   (creset),
`ifdef LFSR_SCAN_EN
    .scan_en (cscan_en),
    .scan_in (cscan_in),
`endif
    .state   (cstate),
    .fb      (cfb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       d1;
    logic [3:0] d4;
    logic       exp1;
    logic [3:0] exp4;
  } vec_t;

  vec_t vecs[6];

  lfsr_state_t st_m;
  logic        fb_m;
  lfsr_state_t st_n;

  initial begin
    vecs[0] = '{1'b1, 4'h5, 1'b1, 4'h5};
    vecs[1] = '{1'b0, 4'h3, 1'b0, 4'h3};
    vecs[2] = '{1'b1, 4'hC, 1'b1, 4'hC};
    vecs[3] = '{1'b1, 4'h0, 1'b1, 4'h0};
    vecs[4] = '{1'b0, 4'hF, 1'b0, 4'hF};
    vecs[5] = '{1'b0, 4'h9, 1'b0, 4'h9};

    reset  = 1'b1;
    creset = 1'b1;
    d1     = 1'b1;
    d4     = 4'hF;
`ifdef LFSR_SCAN_EN
    scan_en  = 1'b0;
    scan_in1 = 1'b0;
    scan_in4 = 4'h0;
    cscan_en = 1'b0;
    cscan_in = 1'b0;
`endif

    // Reset pulse 0-10 ns; the edge at 5 ns must be ignored.
    #7;
    chk("reset_q1", 64'(q1), 64'd0);
    chk("reset_q4", 64'(q4), 64'hA);
    #3;
    reset = 1'b0;
    #2;
    chk("release_no_capture_q1", 64'(q1), 64'd0);
    chk("release_no_capture_q4", 64'(q4), 64'hA);

    // First capture at the 15 ns edge.
    @(posedge clk); #1;
    chk("capture_q1", 64'(q1), 64'd1);
    chk("capture_q4", 64'(q4), 64'hF);
    d1 = 1'b0;
    d4 = 4'h2;
    @(posedge clk); #1;
    chk("capture0_q1", 64'(q1), 64'd0);
    chk("capture0_q4", 64'(q4), 64'h2);

    // Table of one-edge captures.
    for (int i = 0; i < 6; i++) begin
      d1 = vecs[i].d1;
      d4 = vecs[i].d4;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_q1", i), 64'(q1), 64'(vecs[i].exp1));
      chk($sformatf("vec%0d_q4", i), 64'(q4), 64'(vecs[i].exp4));
    end

    // Async clear mid-cycle, hold through an edge, release between edges.
    d1 = 1'b1;
    d4 = 4'h6;
    @(posedge clk); #1;
    chk("pre_clear_q1", 64'(q1), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_clear_q1", 64'(q1), 64'd0);
    chk("async_clear_q4", 64'(q4), 64'hA);
    @(posedge clk); #1;
    chk("held_reset_q1", 64'(q1), 64'd0);
    chk("held_reset_q4", 64'(q4), 64'hA);
    #3;
    reset = 1'b0;
    #1;
    chk("released_q1", 64'(q1), 64'd0);
    @(posedge clk); #1;
    chk("follow_q1", 64'(q1), 64'd1);
    chk("follow_q4", 64'(q4), 64'h6);

    // Reset raised on a clock edge wins over the capture.
    d1 = 1'b0;
    d4 = 4'h5;
    @(posedge clk);
    reset = 1'b1;
    #1;
    chk("coincident_q1", 64'(q1), 64'd0);
    chk("coincident_q4", 64'(q4), 64'hA);
    #3;
    reset = 1'b0;
    d1 = 1'b1;
    @(posedge clk); #1;
    chk("after_coincident_q1", 64'(q1), 64'd1);
    chk("after_coincident_q4", 64'(q4), 64'h5);

`ifdef LFSR_SCAN_EN
    scan_en  = 1'b1;
    scan_in1 = 1'b1;
    scan_in4 = 4'h3;
    d1 = 1'b0;
    d4 = 4'h0;
    @(posedge clk); #1;
    chk("scan_q1", 64'(q1), 64'd1);
    chk("scan_q4", 64'(q4), 64'h3);
    scan_en = 1'b0;
    @(posedge clk); #1;
    chk("unscan_q1", 64'(q1), 64'd0);
    chk("unscan_q4", 64'(q4), 64'h0);
    scan_en = 1'b1;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("scan_reset_q1", 64'(q1), 64'd0);
    chk("scan_reset_q4", 64'(q4), 64'hA);
    reset   = 1'b0;
    scan_en = 1'b0;
`endif

    // Chain: check reset state, release between edges, then 33 cycles vs model.
    @(negedge clk);
    chk("chain_reset_state", 64'(cstate), 64'd0);
    chk("chain_reset_fb", 64'(cfb), 64'd0);
    creset = 1'b0;
    st_m = '0;
    fb_m = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      st_n = {st_m[LFSR_LEN-2:0], fb_m};
      fb_m = ~(st_m[24] ^ st_m[35]);
      st_m = st_n;
      chk($sformatf("chain_state_c%0d", c), 64'(cstate), 64'(st_m));
      chk($sformatf("chain_fb_c%0d", c), 64'(cfb), 64'(fb_m));
      if (c == 1) chk("chain_fb_first", 64'(cfb), 64'd1);
      if (c == 2) chk("chain_q0_second", 64'(cstate[0]), 64'd1);
      if (c <= 26)
        chk($sformatf("chain_fill_c%0d", c), 64'(cstate), (64'd1 << (c - 1)) - 64'd1);
      if (c == 26) chk("chain_q24_set", 64'(cstate[24]), 64'd1);
      if (c == 27) chk("chain_fb_drop", 64'(cfb), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_lfsr
